pipeline_hazard_ctrl: RTL and testbench

- Central hazard controller for the 5-stage MIPS pipeline. It drives the execute datapath's forwarding selects and the pipeline-register enables and flushes.
- It handles three sequencing cases:
  - load-use stalls, detected in ID against EX;
  - taken branch/jump flushes, resolved in EX, with the target from the EX adder;
  - fixed-latency multi-cycle EX operations (mult/div), which hold the front of the pipe.
- It keeps a saturating performance counter of stall cycles.

---
 rtl/pipeline_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard, forwarding and stall control for a 5-stage MIPS pipeline
//
// Purpose: steers the EX forwarding muxes, gates/flushes the pipeline registers for
// load-use stalls, taken branches/jumps and fixed-latency multi-cycle EX ops, and
// counts stalled cycles.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-low reset
//   id_rs, id_rt, id_uses_rt      source registers of the ID instruction
//   ex_rs, ex_rt, ex_dest         sources / destination of the EX instruction
//   ex_MemRead, ex_Branch, ex_zero, ex_Jump, ex_multicycle   EX control
//   mem_rd, mem_RegWrite          MEM-stage writeback
//   wb_rd, wb_RegWrite            WB-stage writeback
//   pc_write, pc_src              PC enable / take EX target
//   ifid_write, ifid_flush        IF/ID enable / clear
//   idex_write, idex_flush        ID/EX enable / bubble
//   exmem_flush                   EX/MEM bubble
//   fwd_a, fwd_b                  operand selects: 00 regfile, 10 MEM, 01 WB
//   stall_cycles                  saturating count of cycles with pc_write=0
module pipeline_hazard_ctrl #(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_dest,
  input  logic             ex_MemRead,
  input  logic             ex_Branch,
  input  logic             ex_zero,
  input  logic             ex_Jump,
  input  logic             ex_multicycle,
  input  logic [4:0]       mem_rd,
  input  logic             mem_RegWrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_RegWrite,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MC_W = $clog2(MC_LATENCY);
  // EX cycle 1 is spent in RUN and the release cycle sees mc_cnt==0,
  // so the countdown starts at MC_LATENCY-2.
  localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_LATENCY - 2);

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [MC_W-1:0] mc_cnt, mc_cnt_nxt;
  logic            taken, lu;

  // MEM beats WB; $0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] m_rd,
    input logic       m_we,
    input logic [4:0] w_rd,
    input logic       w_we
  );
    if (m_we && (m_rd != 5'd0) && (m_rd == src)) return 2'b10;
    if (w_we && (w_rd != 5'd0) && (w_rd == src)) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    taken = (ex_Branch & ex_zero) | ex_Jump;
    lu    = ex_MemRead && (ex_dest != 5'd0) &&
            ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));

    pc_write    = 1'b1;
    pc_src      = 1'b0;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    fwd_a       = fwd_sel(ex_rs, mem_rd, mem_RegWrite, wb_rd, wb_RegWrite);
    fwd_b       = fwd_sel(ex_rt, mem_rd, mem_RegWrite, wb_rd, wb_RegWrite);
    state_nxt   = state;
    mc_cnt_nxt  = mc_cnt;

    if (!rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;
      state_nxt   = RUN;
      mc_cnt_nxt  = '0;
    end else begin
      case (state)
        RUN: begin
          if (taken) begin
            // ID holds a wrong-path instruction, so any load-use on it is moot.
            pc_src     = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (ex_multicycle) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_flush = 1'b1;
            mc_cnt_nxt  = MC_LOAD;
            state_nxt   = MC_WAIT;
          end else if (lu) begin
            // One bubble suffices: next cycle EX holds the bubble, not the load.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
        end
        MC_WAIT: begin
          if (mc_cnt == '0) begin
            // Final EX cycle: normal enables let the result into EX/MEM.
            state_nxt = RUN;
          end else begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_flush = 1'b1;
            mc_cnt_nxt  = mc_cnt - 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      mc_cnt       <= '0;
      stall_cycles <= '0;
    end else begin
      state  <= state_nxt;
      mc_cnt <= mc_cnt_nxt;
      if (!pc_write && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int L  = 4;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_rd, wb_rd;
  logic id_uses_rt, ex_MemRead, ex_Branch, ex_zero, ex_Jump, ex_multicycle;
  logic mem_RegWrite, wb_RegWrite;

  logic pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush, exmem_flush;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cycles;

  logic s_pc_write, s_pc_src, s_ifid_write, s_ifid_flush, s_idex_write, s_idex_flush, s_exmem_flush;
  logic [1:0] s_fwd_a, s_fwd_b;
  logic [1:0] s_stall;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  // Model state: how many cycles the current multi-cycle op has occupied EX
  // (0 = none), and the expected stall count.
  int     m_age = 0;
  longint m_cnt = 0;
  localparam longint CNT_MAX = (64'd1 << CW) - 1;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MC_LATENCY(L), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .ex_MemRead(ex_MemRead), .ex_Branch(ex_Branch), .ex_zero(ex_zero),
    .ex_Jump(ex_Jump), .ex_multicycle(ex_multicycle),
    .mem_rd(mem_rd), .mem_RegWrite(mem_RegWrite),
    .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite),
    .pc_write(pc_write), .pc_src(pc_src),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cycles(stall_cycles)
  );

  pipeline_hazard_ctrl #(.MC_LATENCY(2), .CNT_W(2)) u_small (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .ex_MemRead(ex_MemRead), .ex_Branch(ex_Branch), .ex_zero(ex_zero),
    .ex_Jump(ex_Jump), .ex_multicycle(ex_multicycle),
    .mem_rd(mem_rd), .mem_RegWrite(mem_RegWrite),
    .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite),
    .pc_write(s_pc_write), .pc_src(s_pc_src),
    .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
    .idex_write(s_idex_write), .idex_flush(s_idex_flush),
    .exmem_flush(s_exmem_flush), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .stall_cycles(s_stall)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h", phase, name, act, exp);
    end
  endtask

  function automatic logic [1:0] fwd_rule(input logic [4:0] src);
    if (mem_RegWrite && mem_rd != 0 && mem_rd == src) return 2'b10;
    if (wb_RegWrite && wb_rd != 0 && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // Expected outputs from the hazard rules, checked against the DUT every cycle.
  task automatic compare();
    bit taken, lu, hold;
    bit e_pcw, e_src, e_ifw, e_iff, e_idw, e_idf, e_exf;
    logic [1:0] e_fa, e_fb;
    int next_age;
    if (!rst) begin m_age = 0; m_cnt = 0; end
    taken = (ex_Branch && ex_zero) || ex_Jump;
    lu = ex_MemRead && ex_dest != 0 && (ex_dest == id_rs || (id_uses_rt && ex_dest == id_rt));
    e_pcw = 1; e_src = 0; e_ifw = 1; e_iff = 0; e_idw = 1; e_idf = 0; e_exf = 0;
    e_fa = fwd_rule(ex_rs);
    e_fb = fwd_rule(ex_rt);
    hold = 0;
    next_age = 0;
    if (!rst) begin
      e_pcw = 0; e_ifw = 0; e_idw = 0; e_iff = 1; e_idf = 1; e_exf = 1; e_fa = 0; e_fb = 0;
    end else if (m_age >= 2 && m_age < L) begin
      hold = 1; next_age = m_age + 1;
    end else if (m_age == L) begin
      next_age = 0;
    end else if (taken) begin
      e_src = 1; e_iff = 1; e_idf = 1;
    end else if (ex_multicycle) begin
      hold = 1; next_age = 2;
    end else if (lu) begin
      e_pcw = 0; e_ifw = 0; e_idf = 1;
    end
    if (hold) begin e_pcw = 0; e_ifw = 0; e_idw = 0; e_exf = 1; end
    check("pc_write", pc_write, e_pcw);
    check("pc_src", pc_src, e_src);
    check("ifid_write", ifid_write, e_ifw);
    check("ifid_flush", ifid_flush, e_iff);
    check("idex_write", idex_write, e_idw);
    check("idex_flush", idex_flush, e_idf);
    check("exmem_flush", exmem_flush, e_exf);
    check("fwd_a", fwd_a, e_fa);
    check("fwd_b", fwd_b, e_fb);
    check("stall_cycles", stall_cycles, m_cnt);
    if (rst) begin
      m_age = next_age;
      if (!e_pcw && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  // Compare at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 0;
    ex_rs = 5'd3; ex_rt = 5'd4; ex_dest = 5'd0;
    ex_MemRead = 0; ex_Branch = 0; ex_zero = 0; ex_Jump = 0; ex_multicycle = 0;
    mem_rd = 5'd0; mem_RegWrite = 0; wb_rd = 5'd0; wb_RegWrite = 0;
  endtask

  task automatic set_lu();
    ex_MemRead = 1; ex_dest = 5'd8; id_rt = 5'd8; id_uses_rt = 1;
  endtask

  initial begin
    rst = 0;
    set_idle();
    phase = "reset";
    #1;
    check("rst_pcw", pc_write, 0);
    check("rst_flush", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
    check("rst_cnt", stall_cycles, 0);
    tick(); tick();
    rst = 1;
    #1 check("rel_pcw", pc_write, 1);
    tick();

    phase = "fwd";
    mem_rd = 5; mem_RegWrite = 1; wb_rd = 5; wb_RegWrite = 1; ex_rs = 5; ex_rt = 0;
    #1 check("mem_pri", {fwd_a, fwd_b}, 4'b1000);
    tick();
    mem_rd = 0;
    #1 check("wb_only", fwd_a, 2'b01);
    tick();
    mem_rd = 7; ex_rs = 7; ex_rt = 5;
    tick();
    mem_RegWrite = 0; wb_RegWrite = 0;
    tick();

    phase = "loaduse";
    set_idle(); set_lu();
    #1 check("lu_pcw", {pc_write, ifid_write, idex_flush}, 3'b001);
    check("lu_cnt0", stall_cycles, 0);
    tick();
    set_idle();
    #1 check("lu_after", pc_write, 1);
    check("lu_cnt1", stall_cycles, 1);
    tick();
    ex_MemRead = 1; ex_dest = 9; id_rs = 9; id_uses_rt = 0;
    tick();
    set_idle();
    ex_MemRead = 1; ex_dest = 8; id_rt = 8; id_uses_rt = 0;
    #1 check("no_rt_use", pc_write, 1);
    tick();

    phase = "branch";
    set_idle(); set_lu(); ex_Branch = 1; ex_zero = 1;
    #1 check("taken", {pc_src, ifid_flush, idex_flush, pc_write}, 4'b1111);
    tick();
    set_idle();
    #1 check("taken_cnt", stall_cycles, 2);
    tick();
    set_lu(); ex_Branch = 1; ex_zero = 0;
    tick();
    set_idle(); set_lu(); ex_Jump = 1;
    tick();

    phase = "mc";
    set_idle(); ex_multicycle = 1;
    mem_rd = 3; mem_RegWrite = 1; ex_rs = 3;
    for (int i = 0; i < 3; i++) begin
      #1 check("mc_hold", {pc_write, exmem_flush}, 2'b01);
      tick();
      mem_RegWrite = 0; wb_rd = 3; wb_RegWrite = 1;
    end
    #1 check("mc_rel", {pc_write, exmem_flush, idex_write}, 3'b101);
    check("mc_cnt", stall_cycles, 6);
    tick();
    set_idle();
    tick();
    ex_multicycle = 1; ex_Jump = 1;
    #1 check("mc_taken", {pc_src, pc_write, exmem_flush}, 3'b110);
    tick();
    set_idle(); ex_multicycle = 1; set_lu();
    tick(); tick(); tick();
    #1 check("mclu_rel", pc_write, 1);
    check("mclu_cnt", stall_cycles, 9);
    tick();
    ex_multicycle = 0;
    #1 check("lu_later", pc_write, 0);
    tick();
    set_idle();
    tick();

    phase = "zero";
    mem_rd = 0; mem_RegWrite = 1; ex_rs = 0;
    #1 check("z_fwd", fwd_a, 2'b00);
    tick();
    set_idle(); ex_MemRead = 1; ex_dest = 0; id_rs = 0;
    #1 check("z_lu", pc_write, 1);
    tick();

    phase = "rst_mc";
    set_idle(); ex_multicycle = 1; mem_rd = 3; mem_RegWrite = 1; ex_rs = 3;
    tick();
    #1 rst = 0;
    #1 check("arst_ctl", {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, pc_src}, 7'b0001110);
    check("arst_fwd", fwd_a, 2'b00);
    check("arst_cnt", stall_cycles, 0);
    tick();
    rst = 1; set_idle();
    #1 check("arst_rel", pc_write, 1);
    check("arst_cnt2", stall_cycles, 0);
    tick();

    phase = "sat";
    set_lu();
    for (int i = 0; i < 5; i++) tick();
    set_idle();
    #1 check("sat_small", s_stall, 2'd3);
    check("sat_main", stall_cycles, 5);
    check("small_idle", {s_pc_src, s_ifid_flush, s_idex_flush, s_fwd_a, s_fwd_b}, 7'b0);
    tick();
    ex_multicycle = 1;
    #1 check("s_mc1", {s_pc_write, s_ifid_write, s_idex_write, s_exmem_flush}, 4'b0001);
    tick();
    #1 check("s_mc2", {s_pc_write, s_exmem_flush}, 2'b10);
    check("mc2_main", pc_write, 0);
    tick(); tick();
    ex_multicycle = 0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
